mplier_mac_pipe: RTL and testbench
==================================

Name: mplier_mac_pipe

Overview:
Pipelined multiply-accumulate stage wrapped around the combinational 16x16 radix-8 Booth/Wallace multiplier (mplier16x16).
- Registers signed operands, registers the 32-bit product, then accumulates products over a burst of beats delimited by in_last.
- Delivers one accumulated result per burst on a valid/ready output.
- Sits between the operand stream source and the result consumer; it is the first sequential consumer of the multiplier's product.

Parameters:
- ACC_W, 40: accumulator/result width, signed, min 32.
- LEN_W, 8: beat-counter width; counter saturates at 2^LEN_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush; highest priority
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&&in_ready
- in_mcand  in  16  signed multiplicand
- in_mplier  in  16  signed multiplier
- in_last  in  1  final beat of burst
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  signed burst sum
- out_count  out  LEN_W  beats in burst (saturating)
- out_ovf  out  1  signed overflow occurred in burst

Behaviour:
- Reset (rst_n low, async): s1_v=0, s2_v=0, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0.
- Stall: en = !(out_valid && !out_ready). in_ready = en. When en=0, all pipeline registers, acc, cnt and ovf hold.
- S1 (on en): s1 operands/last <= inputs; s1_v <= in_valid.
- S2 (on en): s2_prod <= mplier16x16(s1_mplier, s1_mcand), 32-bit signed; s2_last <= s1_last; s2_v <= s1_v.
- ACC (on en && s2_v):
  - sum = acc + sign-extend(s2_prod) to ACC_W.
  - ov = operands' sign bits equal and sum sign differs.
  - If s2_last=0: acc <= sum; cnt <= sat(cnt+1); ovf <= ovf|ov.
  - If s2_last=1: out_acc <= sum; out_count <= sat(cnt+1); out_ovf <= ovf|ov; out_valid <= 1; acc, cnt, ovf <= 0 (next burst starts clean).
- Latency: a beat accepted at edge E contributes at edge E+2. out_valid rises after the edge at which the last beat's product is accumulated: E_last+2.
- Throughput: one beat per cycle while out_ready is high, or while no result is pending.
- Output handshake:
  - out_valid falls on an edge with out_ready=1 and no new result.
  - If out_ready=1 and a new last beat completes on the same edge, out_valid stays 1 and the outputs update to the new burst.
  - out_acc, out_count and out_ovf are stable while out_valid=1 && out_ready=0.
- Single-beat burst (in_last on the first beat) is legal: out_count=1.
- Bubbles (in_valid=0) mid-burst do not change acc.
- clear=1 at an edge:
  - s1_v, s2_v, acc, cnt, ovf <= 0; out_valid <= 0.
  - in_ready is still driven by en, but the beat accepted at that edge is discarded.
  - out_acc, out_count and out_ovf hold their values.
- Wrap (default): sum is truncated to ACC_W bits.
- Counter: cnt stops at 2^LEN_W-1; no wrap.

Optional Feature:
- MAC_SAT_EN defined: when ov=1, the value stored (acc or out_acc) is clamped to the signed max if the sum was positive-overflowing, or to the signed min if negative-overflowing. Later beats accumulate from the clamped value. out_ovf still reports overflow.
- MAC_SAT_EN undefined: two's-complement wrap; out_ovf is the only indication.

Test Plan:
- Single beat (3,4,last), out_ready=1 -> out_valid after edge E+2; out_acc=12, out_count=1, out_ovf=0; out_valid falls next edge.
- Back-to-back burst (3,4),(-2,5),(100,-7,last) -> out_acc=-698, out_count=3; next burst (-1,-1,last) issued immediately -> out_acc=1, out_count=1, no gap beyond pipeline latency.
- ACC_W=32, beats (0x8000,0x8000),(0x8000,0x8000,last) -> wrap build: out_acc=0x80000000, out_ovf=1; MAC_SAT_EN build: out_acc=0x7FFFFFFF, out_ovf=1.
- Backpressure: out_ready=0 while a result is pending with a second burst in flight -> in_ready=0, outputs held 5 cycles. Raise out_ready -> first result consumed, second completes correctly with no beat lost or duplicated.
- clear asserted after 2 of 4 beats -> out_valid=0; the following burst (7,6,last) gives out_acc=42, out_count=1.
- rst_n pulsed low asynchronously mid-burst and between clock edges -> all outputs 0 immediately; a subsequent burst (-32768,-32768,last) -> out_acc=1073741824.

Source files
------------

// File: rtl/mplier_mac_pipe.sv
// Pipelined multiply-accumulate stage around a radix-8 Booth / Wallace-tree 16x16 signed multiplier.
// Build option: define MAC_SAT_EN to clamp stored sums on signed overflow (default wraps).

module mplier_mac_pipe #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_mcand,
  input  logic [15:0]      in_mplier,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);

  logic [15:0]      s1_mcand_q, s1_mcand_d;
  logic [15:0]      s1_mplier_q, s1_mplier_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_v_q, s1_v_d;
  logic [31:0]      s2_prod_q, s2_prod_d;
  logic             s2_last_q, s2_last_d;
  logic             s2_v_q, s2_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [LEN_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             en;
  logic [31:0]      prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_val;
  logic [LEN_W-1:0] cnt_inc;
  logic             ov;

  mplier16x16 u_mul (
    .mplier  (s1_mplier_q),
    .mcand   (s1_mcand_q),
    .product (prod)
  );

  assign en        = !(out_valid_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  assign prod_ext = ACC_W'($signed(s2_prod_q));
  assign sum      = acc_q + prod_ext;
  assign ov       = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);

  // With saturation the overflow direction follows the (shared) operand sign.
  always_comb begin
    acc_val = sum;
`ifdef MAC_SAT_EN
    if (ov) begin
      acc_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s1_mcand_d  = s1_mcand_q;
    s1_mplier_d = s1_mplier_q;
    s1_last_d   = s1_last_q;
    s1_v_d      = s1_v_q;
    s2_prod_d   = s2_prod_q;
    s2_last_d   = s2_last_q;
    s2_v_d      = s2_v_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      s1_v_d      = 1'b0;
      s2_v_d      = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (en) begin
      s1_mcand_d  = in_mcand;
      s1_mplier_d = in_mplier;
      s1_last_d   = in_last;
      s1_v_d      = in_valid;
      s2_prod_d   = prod;
      s2_last_d   = s1_last_q;
      s2_v_d      = s1_v_q;
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (s2_v_q) begin
        if (s2_last_q) begin
          out_acc_d   = acc_val;
          out_count_d = cnt_inc;
          out_ovf_d   = ovf_q | ov;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_val;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | ov;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mcand_q  <= '0;
      s1_mplier_q <= '0;
      s1_last_q   <= 1'b0;
      s1_v_q      <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_mcand_q  <= s1_mcand_d;
      s1_mplier_q <= s1_mplier_d;
      s1_last_q   <= s1_last_d;
      s1_v_q      <= s1_v_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
      s2_v_q      <= s2_v_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

module mplier16x16 (
  input  logic [15:0] mplier,
  input  logic [15:0] mcand,
  output logic [31:0] product
);

  logic [18:0] yx;
  logic [31:0] m1, m2, m3, m4;
  logic [31:0] pp [6];
  logic [31:0] corr;
  logic [31:0] sel;
  logic [3:0]  win;
  logic [63:0] l1a, l1b, l2, l3, l4;

  // 3:2 compressor over a whole row; result is {carry, sum}.
  function automatic logic [63:0] csa(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return {((a & b) | (a & c) | (b & c)) << 1, a ^ b ^ c};
  endfunction

  // Negative digits use the one's complement; the +1 is gathered into corr.
  always_comb begin
    win  = '0;
    sel  = '0;
    corr = '0;
    yx   = {mplier[15], mplier[15], mplier, 1'b0};
    m1   = {{16{mcand[15]}}, mcand};
    m2   = {m1[30:0], 1'b0};
    m3   = m1 + m2;
    m4   = {m1[29:0], 2'b00};
    for (int unsigned i = 0; i < 6; i++) begin
      win = yx[3*i +: 4];
      case (win)
        4'b0001, 4'b0010, 4'b1101, 4'b1110: sel = m1;
        4'b0011, 4'b0100, 4'b1011, 4'b1100: sel = m2;
        4'b0101, 4'b0110, 4'b1001, 4'b1010: sel = m3;
        4'b0111, 4'b1000:                   sel = m4;
        default:                            sel = '0;
      endcase
      pp[i]     = (win[3] ? ~sel : sel) << (3*i);
      corr[3*i] = win[3];
    end
  end

  assign l1a     = csa(pp[0], pp[1], pp[2]);
  assign l1b     = csa(pp[3], pp[4], pp[5]);
  assign l2      = csa(l1a[31:0], l1a[63:32], l1b[31:0]);
  assign l3      = csa(l2[31:0], l2[63:32], l1b[63:32]);
  assign l4      = csa(l3[31:0], l3[63:32], corr);
  assign product = l4[31:0] + l4[63:32];

endmodule

// File: tb/tb_mplier_mac_pipe.sv
// Randomised and directed bench for mplier_mac_pipe, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mplier_mac_pipe;

  localparam int     ACC_W   = 32;
  localparam int     LEN_W   = 4;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W-1));
  localparam int     CNT_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, clear, in_valid, in_ready, in_last;
  logic             out_valid, out_ready, out_ovf;
  logic [15:0]      in_mcand, in_mplier;
  logic [ACC_W-1:0] out_acc;
  logic [LEN_W-1:0] out_count;

  always #5 clk = ~clk;

  mplier_mac_pipe #(.ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  typedef struct { int mc; int mp; bit last; int age; } beat_t;
  typedef struct { longint acc; int cnt; bit ovf; } res_t;

  beat_t  pend[$];
  res_t   exp_q[$];
  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     last_fire;
  int     n_checks = 0;
  int     n_pass   = 0;
  longint exp_ovf_acc;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic longint wrap(input longint v);
    longint m, r;
    m = longint'(1) << ACC_W;
    r = v % m;
    if (r > ACC_MAX) r -= m;
    else if (r < ACC_MIN) r += m;
    return r;
  endfunction

  function automatic void model_flush();
    pend.delete();
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void absorb(input beat_t b);
    longint s;
    bit     ov;
    res_t   r;
    s  = m_acc + longint'(b.mc) * longint'(b.mp);
    ov = (s > ACC_MAX) || (s < ACC_MIN);
`ifdef MAC_SAT_EN
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
`else
    s = wrap(s);
`endif
    if (b.last) begin
      r.acc = s;
      r.cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      r.ovf = m_ovf | ov;
      exp_q.push_back(r);
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      m_acc = s;
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_ovf = m_ovf | ov;
    end
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step();
    bit    en_exp;
    beat_t b;
    #1;
    en_exp = !(exp_q.size() != 0 && !out_ready);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("in_ready", in_ready, en_exp);
    if (exp_q.size() != 0) begin
      check_eq("out_acc", $signed(out_acc), exp_q[0].acc);
      check_eq("out_count", out_count, exp_q[0].cnt);
      check_eq("out_ovf", out_ovf, exp_q[0].ovf);
    end
    last_fire = in_valid && en_exp;
    b.mc   = int'($signed(in_mcand));
    b.mp   = int'($signed(in_mplier));
    b.last = in_last;
    b.age  = 0;
    @(posedge clk);
    if (rst_n) begin
      if (clear) begin
        model_flush();
      end else if (en_exp) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        foreach (pend[k]) pend[k].age++;
        while (pend.size() != 0 && pend[0].age >= 2) absorb(pend.pop_front());
        if (last_fire) pend.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input int mc, input int mp, input bit last, input bit v);
    in_mcand  = 16'(mc);
    in_mplier = 16'(mp);
    in_last   = last;
    in_valid  = v;
  endtask

  task automatic wait_result(input string tag, input longint acc, input int cnt, input bit ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, ".valid"}, out_valid, 1);
    check_eq({tag, ".acc"}, $signed(out_acc), acc);
    check_eq({tag, ".count"}, out_count, cnt);
    check_eq({tag, ".ovf"}, out_ovf, ovf);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int remain;
    rst_n     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    model_flush();
    @(negedge clk);
    step();
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.out_acc", out_acc, 0);
    check_eq("rst.out_count", out_count, 0);
    check_eq("rst.out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    step();

    // Single beat, latency of two edges.
    drive(3, 4, 1, 1); step();
    drive(0, 0, 0, 0); step();
    check_eq("single.early", out_valid, 0);
    step();
    check_eq("single.valid", out_valid, 1);
    check_eq("single.acc", $signed(out_acc), 12);
    check_eq("single.count", out_count, 1);
    check_eq("single.ovf", out_ovf, 0);
    step();
    check_eq("single.fall", out_valid, 0);

    // Back-to-back bursts.
    drive(3, 4, 0, 1);    step();
    drive(-2, 5, 0, 1);   step();
    drive(100, -7, 1, 1); step();
    drive(-1, -1, 1, 1);  step();
    drive(0, 0, 0, 0);    step();
    check_eq("b2b.acc0", $signed(out_acc), -698);
    check_eq("b2b.count0", out_count, 3);
    step();
    check_eq("b2b.valid1", out_valid, 1);
    check_eq("b2b.acc1", $signed(out_acc), 1);
    check_eq("b2b.count1", out_count, 1);
    step();

    // Signed overflow of the 32-bit accumulator.
`ifdef MAC_SAT_EN
    exp_ovf_acc = ACC_MAX;
`else
    exp_ovf_acc = ACC_MIN;
`endif
    drive(-32768, -32768, 0, 1); step();
    drive(-32768, -32768, 1, 1); step();
    drive(0, 0, 0, 0);
    wait_result("ovf", exp_ovf_acc, 2, 1);
    step();

    // Backpressure with a second burst in flight and a third beat waiting.
    out_ready = 1'b0;
    drive(1, 2, 1, 1); step();
    drive(3, 3, 0, 1); step();
    drive(4, 4, 1, 1); step();
    drive(5, -6, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp.in_ready", in_ready, 0);
      check_eq("bp.acc_hold", $signed(out_acc), 2);
      step();
    end
    out_ready = 1'b1;
    step();
    drive(0, 0, 0, 0);
    wait_result("bp.b", 25, 2, 0);
    step();
    wait_result("bp.c", -30, 1, 0);
    step();

    // Clear mid-burst discards partial sums and the beat taken on the clear edge.
    drive(1, 1, 0, 1); step();
    drive(2, 2, 0, 1); step();
    drive(9, 9, 1, 1); clear = 1'b1; step();
    clear = 1'b0;
    drive(0, 0, 0, 0);
    check_eq("clr.valid", out_valid, 0);
    check_eq("clr.acc_hold", $signed(out_acc), -30);
    step(); step(); step();
    drive(7, 6, 1, 1); step();
    drive(0, 0, 0, 0);
    wait_result("clr.next", 42, 1, 0);
    step();

    // Asynchronous reset between edges, mid-burst.
    drive(5, 5, 0, 1); step();
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.valid", out_valid, 0);
    check_eq("arst.acc", out_acc, 0);
    check_eq("arst.count", out_count, 0);
    check_eq("arst.ovf", out_ovf, 0);
    model_flush();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    drive(-32768, -32768, 1, 1); step();
    drive(0, 0, 0, 0);
    wait_result("arst.next", 1073741824, 1, 0);
    step();

    // Randomised traffic: bursts up to 20 beats, random backpressure and rare clears.
    remain    = 0;
    last_fire = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 199) == 0);
      if (!in_valid || last_fire) begin
        if ($urandom_range(0, 9) < 8) begin
          if (remain == 0) remain = $urandom_range(1, 20);
          in_mcand  = rand_op();
          in_mplier = rand_op();
          in_last   = (remain == 1);
          in_valid  = 1'b1;
          remain--;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
